// File: rtl/vga_pattern_gen_if.sv
// Pixel-side bundle of the VGA pattern generator: strobe and mode select in,
// sync/colour/status out. The generator takes the master side.
interface vga_pattern_gen_if #(
  parameter int COLOR_BITS = 4
);
  logic                  pixel_en;
  logic [1:0]            mode;
  logic                  vga_h_sync;
  logic                  vga_v_sync;
  logic [COLOR_BITS-1:0] vga_r;
  logic [COLOR_BITS-1:0] vga_g;
  logic [COLOR_BITS-1:0] vga_b;
  logic                  video_active;
  logic                  frame_start;
  logic [7:0]            frame_cnt;

  modport master (
    input  pixel_en, mode,
    output vga_h_sync, vga_v_sync, vga_r, vga_g, vga_b,
           video_active, frame_start, frame_cnt
  );

  modport slave (
    output pixel_en, mode,
    input  vga_h_sync, vga_v_sync, vga_r, vga_g, vga_b,
           video_active, frame_start, frame_cnt
  );
endinterface

// File: rtl/vga_pattern_gen.sv
// Parametrised VGA timing and test-pattern generator. Counters and all outputs
// advance only on pixel_en; outputs lag the counter position by one strobe.
module vga_pattern_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit SYNC_POL   = 1'b0,
  parameter int COLOR_BITS = 4,
  parameter int BAR_SHIFT  = 6,
  parameter int CHK_SHIFT  = 5
) (
  input logic                clk,
  input logic                reset,
  vga_pattern_gen_if.master  vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_W     = $clog2(H_TOTAL);
  localparam int V_W     = $clog2(V_TOTAL);
  localparam logic [31:0] CHK_MASK = (32'd1 << CHK_SHIFT) - 32'd1;

  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
      COLOR_BITS < 1 || COLOR_BITS > 8 ||
      BAR_SHIFT + 2 >= $clog2(H_ACTIVE) || CHK_SHIFT >= $clog2(H_ACTIVE)) begin : g_bad_params
    $error("vga_pattern_gen: illegal timing or shift parameters");
  end

  logic [H_W-1:0]        h_cnt;
  logic [V_W-1:0]        v_cnt;
  logic [1:0]            mode_q;
  logic [7:0]            frame_cnt_q;
  logic                  h_last, v_last;
  logic [31:0]           h_x, v_x;
  logic                  visible, hs_on, vs_on;
  logic [2:0]            bar_idx;
  logic                  chk_sel, grid_on;
  logic [7:0]            grad_s;
  logic [COLOR_BITS-1:0] pix_r, pix_g, pix_b;
  logic                  hs_q, vs_q, act_q, fs_q;
  logic [COLOR_BITS-1:0] r_q, g_q, b_q;

  assign h_last  = (h_cnt == H_W'(H_TOTAL - 1));
  assign v_last  = (v_cnt == V_W'(V_TOTAL - 1));
  assign h_x     = 32'(h_cnt);
  assign v_x     = 32'(v_cnt);
  assign visible = (h_x < 32'(H_ACTIVE)) && (v_x < 32'(V_ACTIVE));
  assign hs_on   = (h_x >= 32'(H_ACTIVE + H_FP)) && (h_x < 32'(H_ACTIVE + H_FP + H_SYNC));
  assign vs_on   = (v_x >= 32'(V_ACTIVE + V_FP)) && (v_x < 32'(V_ACTIVE + V_FP + V_SYNC));

  always_comb begin
    bar_idx = h_x[BAR_SHIFT+2 -: 3];
    chk_sel = h_x[CHK_SHIFT] ^ v_x[CHK_SHIFT];
    grad_s  = h_x[7:0] + frame_cnt_q;
    grid_on = (h_x == 32'd0) || (h_x == 32'(H_ACTIVE - 1)) ||
              (v_x == 32'd0) || (v_x == 32'(V_ACTIVE - 1)) ||
              ((h_x & CHK_MASK) == 32'd0) || ((v_x & CHK_MASK) == 32'd0);
    pix_r = '0;
    pix_g = '0;
    pix_b = '0;
    case (mode_q)
      2'd0: begin
        pix_r = {COLOR_BITS{bar_idx[2]}};
        pix_g = {COLOR_BITS{bar_idx[1]}};
        pix_b = {COLOR_BITS{bar_idx[0]}};
      end
      2'd1: begin
        pix_r = {COLOR_BITS{chk_sel}};
        pix_g = {COLOR_BITS{chk_sel}};
        pix_b = {COLOR_BITS{chk_sel}};
      end
      2'd2: begin
        // Top COLOR_BITS of each 8-bit ramp.
        pix_r = COLOR_BITS'(grad_s >> (8 - COLOR_BITS));
        pix_g = COLOR_BITS'(v_x[7:0] >> (8 - COLOR_BITS));
        pix_b = COLOR_BITS'(frame_cnt_q >> (8 - COLOR_BITS));
      end
      default: begin
        pix_r = {COLOR_BITS{grid_on}};
        pix_g = {COLOR_BITS{grid_on}};
        pix_b = {COLOR_BITS{grid_on}};
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      frame_cnt_q <= '0;
      mode_q      <= vga.mode;
      hs_q        <= ~SYNC_POL;
      vs_q        <= ~SYNC_POL;
      r_q         <= '0;
      g_q         <= '0;
      b_q         <= '0;
      act_q       <= 1'b0;
      fs_q        <= 1'b0;
    end else if (vga.pixel_en) begin
      if (h_last) begin
        h_cnt <= '0;
        if (v_last) begin
          v_cnt       <= '0;
          frame_cnt_q <= frame_cnt_q + 8'd1;
          mode_q      <= vga.mode;
        end else begin
          v_cnt <= v_cnt + V_W'(1);
        end
      end else begin
        h_cnt <= h_cnt + H_W'(1);
      end
      hs_q  <= hs_on ? SYNC_POL : ~SYNC_POL;
      vs_q  <= vs_on ? SYNC_POL : ~SYNC_POL;
      r_q   <= visible ? pix_r : '0;
      g_q   <= visible ? pix_g : '0;
      b_q   <= visible ? pix_b : '0;
      act_q <= visible;
      fs_q  <= (h_cnt == '0) && (v_cnt == '0);
    end else begin
      // frame_start is a single clk pulse, not a held pixel value.
      fs_q <= 1'b0;
    end
  end

  assign vga.vga_h_sync   = hs_q;
  assign vga.vga_v_sync   = vs_q;
  assign vga.vga_r        = r_q;
  assign vga.vga_g        = g_q;
  assign vga.vga_b        = b_q;
  assign vga.video_active = act_q;
  assign vga.frame_start  = fs_q;
  assign vga.frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Bench for vga_pattern_gen on a 14x7 raster, with active-low and active-high
// sync builds side by side, checked against a pixel-index reference model.
module tb_vga_pattern_gen;
  localparam int HA = 8, HF = 2, HS = 2, HB = 2;
  localparam int VA = 4, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int CB = 4, BSH = 0, CSH = 1;

  logic clk = 1'b0;
  logic rst_r = 1'b0;
  logic pe_r = 1'b0;
  logic [1:0] mode_r = 2'd0;
  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;

  // reference model state
  int m_p, m_frame, m_mode;
  logic m_hsa, m_vsa, m_act, m_fs;
  logic [11:0] m_rgb;

  always #5 clk = ~clk;

  vga_pattern_gen_if #(.COLOR_BITS(CB)) bus0 ();
  vga_pattern_gen_if #(.COLOR_BITS(CB)) bus1 ();
  assign bus0.pixel_en = pe_r;
  assign bus0.mode     = mode_r;
  assign bus1.pixel_en = pe_r;
  assign bus1.mode     = mode_r;

  vga_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b0), .COLOR_BITS(CB), .BAR_SHIFT(BSH), .CHK_SHIFT(CSH)
  ) u_dut0 (.clk(clk), .reset(rst_r), .vga(bus0));

  vga_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b1), .COLOR_BITS(CB), .BAR_SHIFT(BSH), .CHK_SHIFT(CSH)
  ) u_dut1 (.clk(clk), .reset(rst_r), .vga(bus1));

  function automatic logic [11:0] pix(int h, int v, int md, int fr);
    logic [3:0] r, g, b;
    int idx, s;
    r = 4'h0; g = 4'h0; b = 4'h0;
    case (md)
      0: begin
        idx = (h >> BSH) % 8;
        r = ((idx & 4) != 0) ? 4'hF : 4'h0;
        g = ((idx & 2) != 0) ? 4'hF : 4'h0;
        b = ((idx & 1) != 0) ? 4'hF : 4'h0;
      end
      1: if ((((h >> CSH) ^ (v >> CSH)) & 1) == 1) begin r = 4'hF; g = 4'hF; b = 4'hF; end
      2: begin
        s = (h % 256 + fr) % 256;
        r = 4'(s / 16);
        g = 4'((v % 256) / 16);
        b = 4'(fr / 16);
      end
      default:
        if (h == 0 || h == HA - 1 || v == 0 || v == VA - 1 ||
            h % (1 << CSH) == 0 || v % (1 << CSH) == 0) begin
          r = 4'hF; g = 4'hF; b = 4'hF;
        end
    endcase
    return {r, g, b};
  endfunction

  function automatic logic [23:0] exp_vec(bit pol);
    return {m_hsa ? pol : ~pol, m_vsa ? pol : ~pol, m_rgb, m_act, m_fs, 8'(m_frame)};
  endfunction

  function automatic logic [23:0] obs0();
    return {bus0.vga_h_sync, bus0.vga_v_sync, bus0.vga_r, bus0.vga_g, bus0.vga_b,
            bus0.video_active, bus0.frame_start, bus0.frame_cnt};
  endfunction

  function automatic logic [23:0] obs1();
    return {bus1.vga_h_sync, bus1.vga_v_sync, bus1.vga_r, bus1.vga_g, bus1.vga_b,
            bus1.video_active, bus1.frame_start, bus1.frame_cnt};
  endfunction

  // Drive one clk with the given strobe/reset, advance the model, settle.
  task automatic step(input bit pe, input bit rst);
    int h, v;
    pe_r = pe;
    rst_r = rst;
    @(posedge clk);
    cyc++;
    if (rst) begin
      m_p = 0; m_frame = 0; m_mode = int'(mode_r);
      m_hsa = 0; m_vsa = 0; m_rgb = '0; m_act = 0; m_fs = 0;
    end else if (pe) begin
      h = m_p % HT;
      v = m_p / HT;
      m_act = (h < HA) && (v < VA);
      m_rgb = m_act ? pix(h, v, m_mode, m_frame) : 12'h000;
      m_hsa = (h >= HA + HF) && (h < HA + HF + HS);
      m_vsa = (v >= VA + VF) && (v < VA + VF + VS);
      m_fs = (m_p == 0);
      m_p++;
      if (m_p == HT * VT) begin
        m_p = 0;
        m_frame = (m_frame + 1) % 256;
        m_mode = int'(mode_r);
      end
    end else begin
      m_fs = 0;
    end
    #1;
  endtask

  task automatic test_reset();
    mode_r = 2'd0;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    n_tests++;
    if (obs0() !== 24'hC0_0000) begin
      n_fail++; $display("FAIL reset_pol0 got=%h exp=%h", obs0(), 24'hC00000);
    end
    n_tests++;
    if (obs1() !== 24'h00_0000) begin
      n_fail++; $display("FAIL reset_pol1 got=%h exp=%h", obs1(), 24'h000000);
    end
  endtask

  task automatic test_timing();
    int hs_low = 0, vs_low = 0, last_fs = -1, period = -1;
    for (int i = 0; i < 2 * HT * VT; i++) begin
      step(1'b1, 1'b0);
      n_tests++;
      if (obs0() !== exp_vec(1'b0)) begin
        n_fail++; $display("FAIL timing_pol0 cyc=%0d got=%h exp=%h", cyc, obs0(), exp_vec(1'b0));
      end
      n_tests++;
      if (obs1() !== exp_vec(1'b1)) begin
        n_fail++; $display("FAIL timing_pol1 cyc=%0d got=%h exp=%h", cyc, obs1(), exp_vec(1'b1));
      end
      if (i >= HT * VT) begin
        if (bus0.vga_h_sync === 1'b0) hs_low++;
        if (bus0.vga_v_sync === 1'b0) vs_low++;
      end
      if (bus0.frame_start === 1'b1) begin
        if (last_fs >= 0) period = cyc - last_fs;
        last_fs = cyc;
      end
    end
    n_tests++;
    if (hs_low !== 14) begin n_fail++; $display("FAIL hsync_low_per_frame got=%0d exp=14", hs_low); end
    n_tests++;
    if (vs_low !== 14) begin n_fail++; $display("FAIL vsync_low_per_frame got=%0d exp=14", vs_low); end
    n_tests++;
    if (period !== 98) begin n_fail++; $display("FAIL frame_period got=%0d exp=98", period); end
  endtask

  task automatic test_bars();
    logic [11:0] bars [8];
    bit got;
    bars = '{12'h000, 12'h00F, 12'h0F0, 12'h0FF, 12'hF00, 12'hF0F, 12'hFF0, 12'hFFF};
    mode_r = 2'd0;
    step(1'b1, 1'b1);
    got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      step(1'b1, 1'b0);
      if (bus0.frame_start === 1'b1) got = 1;
    end
    n_tests++;
    if (!got) begin n_fail++; $display("FAIL bars_wait_frame_start got=0 exp=1"); end
    for (int k = 0; k < HT; k++) begin
      n_tests++;
      if (k < HA) begin
        if ({bus0.video_active, bus0.vga_r, bus0.vga_g, bus0.vga_b} !== {1'b1, bars[k]}) begin
          n_fail++; $display("FAIL bars_px%0d got=%h exp=%h", k,
            {bus0.video_active, bus0.vga_r, bus0.vga_g, bus0.vga_b}, {1'b1, bars[k]});
        end
      end else begin
        if ({bus0.video_active, bus0.vga_r, bus0.vga_g, bus0.vga_b} !== 13'h0) begin
          n_fail++; $display("FAIL bars_blank%0d got=%h exp=0", k,
            {bus0.video_active, bus0.vga_r, bus0.vga_g, bus0.vga_b});
        end
      end
      step(1'b1, 1'b0);
    end
  endtask

  task automatic test_pixel_en();
    int last_fs = -1, nper = 0;
    logic prev_fs = 1'b0;
    for (int i = 0; i < 8 * HT * VT; i++) begin
      step((i % 2) == 0, 1'b0);
      n_tests++;
      if (obs0() !== exp_vec(1'b0)) begin
        n_fail++; $display("FAIL pixel_en_pol0 cyc=%0d got=%h exp=%h", cyc, obs0(), exp_vec(1'b0));
      end
      n_tests++;
      if (obs1() !== exp_vec(1'b1)) begin
        n_fail++; $display("FAIL pixel_en_pol1 cyc=%0d got=%h exp=%h", cyc, obs1(), exp_vec(1'b1));
      end
      if (bus0.frame_start === 1'b1) begin
        n_tests++;
        if (prev_fs !== 1'b0) begin n_fail++; $display("FAIL fs_width cyc=%0d got=2+ exp=1", cyc); end
        if (last_fs >= 0) begin
          nper++;
          n_tests++;
          if (cyc - last_fs !== 196) begin
            n_fail++; $display("FAIL strobed_frame_period got=%0d exp=196", cyc - last_fs);
          end
        end
        last_fs = cyc;
      end
      prev_fs = bus0.frame_start;
    end
    n_tests++;
    if (nper == 0) begin n_fail++; $display("FAIL strobed_period_seen got=0 exp=>0"); end
  endtask

  task automatic test_mode_switch();
    bit got = 0;
    mode_r = 2'd0;
    step(1'b1, 1'b1);
    for (int i = 0; i < 40; i++) step(1'b1, 1'b0);
    mode_r = 2'd1;
    for (int i = 0; i < 200 && !got; i++) begin
      step(1'b1, 1'b0);
      n_tests++;
      if (obs0() !== exp_vec(1'b0)) begin
        n_fail++; $display("FAIL mode_hold cyc=%0d got=%h exp=%h", cyc, obs0(), exp_vec(1'b0));
      end
      if (bus0.frame_start === 1'b1) got = 1;
    end
    n_tests++;
    if (!got) begin n_fail++; $display("FAIL mode_wait_frame_start got=0 exp=1"); end
    n_tests++;
    if ({bus0.vga_r, bus0.vga_g, bus0.vga_b} !== 12'h000) begin
      n_fail++; $display("FAIL checker_px0 got=%h exp=000", {bus0.vga_r, bus0.vga_g, bus0.vga_b});
    end
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    n_tests++;
    if ({bus0.vga_r, bus0.vga_g, bus0.vga_b} !== 12'hFFF) begin
      n_fail++; $display("FAIL checker_px2 got=%h exp=FFF", {bus0.vga_r, bus0.vga_g, bus0.vga_b});
    end
  endtask

  task automatic test_reset_mid();
    mode_r = 2'd0;
    step(1'b1, 1'b1);
    for (int i = 0; i < 120; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1);
      n_tests++;
      if (obs0() !== 24'hC0_0000) begin
        n_fail++; $display("FAIL midreset_pol0 got=%h exp=C00000", obs0());
      end
      n_tests++;
      if (obs1() !== 24'h00_0000) begin
        n_fail++; $display("FAIL midreset_pol1 got=%h exp=000000", obs1());
      end
    end
    step(1'b1, 1'b0);
    n_tests++;
    if ({bus0.frame_start, bus0.video_active, bus0.vga_r, bus0.vga_g, bus0.vga_b, bus0.frame_cnt} !==
        {2'b11, 12'h000, 8'h00}) begin
      n_fail++; $display("FAIL midreset_first_px got=%h exp=%h",
        {bus0.frame_start, bus0.video_active, bus0.vga_r, bus0.vga_g, bus0.vga_b, bus0.frame_cnt},
        {2'b11, 12'h000, 8'h00});
    end
  endtask

  task automatic test_random();
    step(1'b1, 1'b1);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) mode_r = 2'($urandom_range(0, 3));
      step(1'($urandom_range(0, 1)), $urandom_range(0, 499) == 0);
      n_tests++;
      if (obs0() !== exp_vec(1'b0)) begin
        n_fail++; $display("FAIL random_pol0 cyc=%0d got=%h exp=%h", cyc, obs0(), exp_vec(1'b0));
      end
      n_tests++;
      if (obs1() !== exp_vec(1'b1)) begin
        n_fail++; $display("FAIL random_pol1 cyc=%0d got=%h exp=%h", cyc, obs1(), exp_vec(1'b1));
      end
    end
  endtask

  task automatic test_frame_wrap();
    int nfs = 0;
    bit saw255 = 0;
    mode_r = 2'd2;
    step(1'b1, 1'b1);
    for (int i = 0; i < 256 * HT * VT; i++) begin
      step(1'b1, 1'b0);
      n_tests++;
      if (obs0() !== exp_vec(1'b0)) begin
        n_fail++; $display("FAIL wrap_pol0 cyc=%0d got=%h exp=%h", cyc, obs0(), exp_vec(1'b0));
      end
      n_tests++;
      if (obs1() !== exp_vec(1'b1)) begin
        n_fail++; $display("FAIL wrap_pol1 cyc=%0d got=%h exp=%h", cyc, obs1(), exp_vec(1'b1));
      end
      if (bus0.frame_start === 1'b1) begin
        n_tests++;
        if ({bus0.frame_cnt, bus0.vga_b} !== {8'(nfs % 256), 4'((nfs % 256) / 16)}) begin
          n_fail++; $display("FAIL wrap_px0_blue frame=%0d got=%h exp=%h", nfs,
            {bus0.frame_cnt, bus0.vga_b}, {8'(nfs % 256), 4'((nfs % 256) / 16)});
        end
        nfs++;
      end
      if (bus0.frame_cnt === 8'd255) saw255 = 1;
    end
    n_tests++;
    if ({saw255, bus0.frame_cnt} !== {1'b1, 8'h00}) begin
      n_fail++; $display("FAIL frame_cnt_wrap got=%h exp=100", {saw255, bus0.frame_cnt});
    end
  endtask

  initial begin
    test_reset();
    test_timing();
    test_bars();
    test_pixel_en();
    test_mode_switch();
    test_reset_mid();
    test_random();
    test_frame_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_pattern_gen.md
Name: vga_pattern_gen

Overview:
- Parametrised successor to the fixed 640x480 VGA demo, for Caravel user-project wrappers.
- Generates VGA sync and pixel timing from configurable porch/sync/active widths and polarity.
- Produces one of four run-time-selectable test patterns at configurable colour depth.
- A pixel-enable strobe lets the block run from a system clock faster than the pixel clock.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_POL, 0, sync asserted level (0 = active-low)
COLOR_BITS, 4, bits per colour channel (1..8)
BAR_SHIFT, 6, log2 colour-bar width in pixels
CHK_SHIFT, 5, log2 checker/grid cell size in pixels

Ports:
clk  input  1  system clock
reset  input  1  synchronous active-high reset
pixel_en  input  1  pixel strobe; counters and outputs advance only when high
mode  input  2  pattern select; sampled at frame boundary
vga_h_sync  output  1  horizontal sync
vga_v_sync  output  1  vertical sync
vga_r  output  COLOR_BITS  red
vga_g  output  COLOR_BITS  green
vga_b  output  COLOR_BITS  blue
video_active  output  1  high while the current output pixel is visible
frame_start  output  1  one-clk pulse with pixel (0,0) output
frame_cnt  output  8  frames completed, wraps 255->0

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Counter widths = clog2 of totals.
- h_cnt runs 0..H_TOTAL-1; v_cnt runs 0..V_TOTAL-1. Both advance only on clk edges with pixel_en=1.
- On h_cnt=H_TOTAL-1: h_cnt->0 and v_cnt increments. On v_cnt=V_TOTAL-1 as well: v_cnt->0 (frame wrap).
- Visible region: h_cnt<H_ACTIVE and v_cnt<V_ACTIVE. Pixel (0,0) is visible.
- H sync is asserted for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC. V sync uses the same rule on v_cnt.
- Asserted sync level = SYNC_POL; inactive level = ~SYNC_POL.
- Output pipeline:
  - All outputs are registered.
  - On a pixel_en edge, outputs load the values computed from the pre-edge (h_cnt,v_cnt) while the counters advance.
  - Latency from counter position to pins: 1 pixel_en edge.
  - Outputs hold while pixel_en=0.
- Blanking: vga_r/g/b = 0 and video_active = 0 outside the visible region.
- Mode latching:
  - mode_q loads mode on the frame-wrap edge only. Mid-frame mode changes are ignored until the next frame.
  - Reset sets mode_q = mode.
- Patterns (F = full scale, all ones; Z = 0):
  - mode 0, colour bars: idx = h_cnt[BAR_SHIFT+2:BAR_SHIFT]; r = idx[2]?F:Z, g = idx[1]?F:Z, b = idx[0]?F:Z. Bars repeat every 8*2^BAR_SHIFT pixels.
  - mode 1, checkerboard: h_cnt[CHK_SHIFT]^v_cnt[CHK_SHIFT] selects white, otherwise black.
  - mode 2, scrolling gradient: s = (h_cnt[7:0]+frame_cnt) mod 256; r = s[7:8-COLOR_BITS], g = v_cnt[7:8-COLOR_BITS], b = frame_cnt[7:8-COLOR_BITS].
  - mode 3, grid: white when h_cnt is 0 or H_ACTIVE-1, v_cnt is 0 or V_ACTIVE-1, or h_cnt/v_cnt low CHK_SHIFT bits are all zero; otherwise black.
- frame_cnt:
  - Increments on the frame-wrap edge; 8-bit wrap.
  - The increment is visible in the mode-2 pattern from the next frame's first pixel onward.
- frame_start: 1 for the single clk cycle after the edge that loads pixel (0,0) outputs; 0 otherwise, including while pixel_en is held low.
- Reset: h_cnt = v_cnt = 0, frame_cnt = 0, syncs at the inactive level, colours = 0, video_active = 0, frame_start = 0.
- Reset overrides pixel_en. Reset mid-frame restarts the frame at (0,0) on the first pixel_en after reset deasserts.
- Parameter legality (checked with an elaboration-time assertion): all timing parameters >= 1; BAR_SHIFT+2 and CHK_SHIFT < clog2(H_ACTIVE).

Test Plan:
- Small config (H 8/2/2/2, V 4/1/1/1, COLOR_BITS=4, BAR_SHIFT=0, CHK_SHIFT=1), pixel_en=1: hsync low for exactly 2 of every 14 clk; vsync low for 14*1 clk per 98-clk frame; frame_start period = 98.
- Same config, mode 0: visible line 0 outputs RGB = 000,00F,0F0,0FF,F00,F0F,FF0,FFF. Porch/sync pixels = 000 with video_active=0.
- pixel_en toggled 1-0-1-0: outputs and counters change only on strobed edges; frame period = 196 clk; frame_start is 1 clk wide.
- mode changed 0->1 mid-frame: current frame stays bars; the next frame's pixel (0,0) = black, (2,0) = white.
- Reset asserted mid-line for 3 clk: outputs at inactive/zero values; frame_cnt = 0; first output after release is pixel (0,0) with frame_start=1.
- Mode 2, run 256 frames: frame_cnt wraps 255->0. Pixel (0,0) blue = frame_cnt[7:4] of the previous frame-wrap value. SYNC_POL=1 build: syncs idle low and assert high.
